// File: rtl/tone_pkg.sv
// Shared types, constants and the divisor table for multi_tone_gen.
// Optional build macro used by the top: TONE_MIX_EN (adds mix_out).
package tone_pkg;

   localparam int NOTE_REST = 13;   // first note index that means "rest"
   localparam int TBL_DEPTH = 14;   // 13 pitched entries plus one rest entry
   localparam int TBL_W     = 8;    // raw table entry width

   typedef struct packed {
      logic [3:0] note;
      logic       highkey;
      logic [1:0] octave;
   } note_cmd_t;

   // Bank 0 is the normal key, bank 1 the high key; the last entry is the rest.
   localparam logic [TBL_W-1:0] BANK0 [TBL_DEPTH] = '{
      8'h33, 8'h30, 8'h56, 8'h2B, 8'h5B, 8'h4D, 8'h26,
      8'h28, 8'h40, 8'h20, 8'h44, 8'h22, 8'h39, 8'h00};
   localparam logic [TBL_W-1:0] BANK1 [TBL_DEPTH] = '{
      8'h30, 8'h2D, 8'h51, 8'h28, 8'h56, 8'h48, 8'h24,
      8'h26, 8'h3D, 8'h1E, 8'h40, 8'h20, 8'h36, 8'h00};

   // Raw divisor for a note; every index at or above the rest index maps to 0.
   function automatic logic [TBL_W-1:0] tbl_entry(input logic bank, input logic [3:0] idx);
      logic [3:0] i;
      i = (idx >= 4'(NOTE_REST)) ? 4'(NOTE_REST) : idx;
      return bank ? BANK1[i] : BANK0[i];
   endfunction

endpackage

// File: rtl/tone_div_table.sv
// Combinational note-to-divisor lookup: bank select, then octave right-shift.
module tone_div_table
   import tone_pkg::*;
#(
   parameter int DIV_W = 10
) (
   input  note_cmd_t        cmd,
   output logic [DIV_W-1:0] div
);

   // Zero-extend the table entry, then shift down by the octave.
   always_comb begin
      div = DIV_W'(tbl_entry(cmd.highkey, cmd.note)) >> cmd.octave;
   end

endmodule

// File: rtl/multi_tone_gen.sv
// Multi-channel square-wave tone generator. Each channel divides a prescaled
// tick by a table divisor; new notes take effect at the next half-period edge.
// Optional build macro: TONE_MIX_EN adds a registered popcount output mix_out.
module multi_tone_gen
   import tone_pkg::*;
#(
   parameter int  NUM_CH   = 2,
   parameter int  DIV_W    = 10,
   parameter int  PRESCALE = 256,
   localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   localparam int MIX_W    = $clog2(NUM_CH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [CH_W-1:0]   cmd_ch,
   input  logic [3:0]        cmd_note,
   input  logic              cmd_highkey,
   input  logic [1:0]        cmd_octave,
   output logic [NUM_CH-1:0] tone_out
`ifdef TONE_MIX_EN
   ,
   output logic [MIX_W-1:0]  mix_out
`endif
);

   // Channel state lives here rather than in the package because its widths follow DIV_W.
   typedef struct packed {
      logic [DIV_W-1:0] active;
      logic [DIV_W-1:0] pending;
      logic [DIV_W-1:0] counter;
      logic             pend_flag;
      logic             phase;
   } chan_state_t;

   // Reload value for a divisor; a zero divisor parks the counter at 0.
   function automatic logic [DIV_W-1:0] load_count(input logic [DIV_W-1:0] d);
      return (d == '0) ? '0 : d - 1'b1;
   endfunction

   logic tick;

   generate
      if (PRESCALE == 1) begin : g_no_presc
         assign tick = 1'b1;
      end else begin : g_presc
         localparam int PW = $clog2(PRESCALE);
         logic [PW-1:0] presc_reg;

         // Free-running prescaler wrapping at PRESCALE-1.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               presc_reg <= '0;
            end else if (presc_reg == PW'(PRESCALE - 1)) begin
               presc_reg <= '0;
            end else begin
               presc_reg <= presc_reg + 1'b1;
            end
         end

         assign tick = (presc_reg == PW'(PRESCALE - 1));
      end
   endgenerate

   note_cmd_t        cmd;
   logic [DIV_W-1:0] cmd_div;
   logic             ch_ok;
   logic             accept;
   logic [NUM_CH-1:0] pend_flags;

   assign cmd = '{note: cmd_note, highkey: cmd_highkey, octave: cmd_octave};

   tone_div_table #(.DIV_W(DIV_W)) u_div_table (
      .cmd (cmd),
      .div (cmd_div)
   );

   assign ch_ok  = (int'(cmd_ch) < NUM_CH);
   assign accept = cmd_valid && cmd_ready && ch_ok;

   // Ready follows the target channel's pending slot; unknown channels always accept and drop.
   always_comb begin
      cmd_ready = 1'b1;
      if (ch_ok) begin
         cmd_ready = !pend_flags[cmd_ch];
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
         chan_state_t st_reg;
         logic        ch_acc;

         assign ch_acc = accept && (int'(cmd_ch) == gi);

         // Per-channel divider: capture commands, apply them at a safe point, count ticks.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               st_reg <= '0;
            end else begin
               if (ch_acc) begin
                  st_reg.pending   <= cmd_div;
                  st_reg.pend_flag <= 1'b1;
               end
               if (st_reg.active == '0) begin
                  // Silent: nothing to glitch, so start right away without waiting for a tick.
                  if (st_reg.pend_flag) begin
                     st_reg.active    <= st_reg.pending;
                     st_reg.counter   <= load_count(st_reg.pending);
                     st_reg.pend_flag <= 1'b0;
                  end
               end else if (tick) begin
                  if (st_reg.counter != '0) begin
                     st_reg.counter <= st_reg.counter - 1'b1;
                  end else if (st_reg.pend_flag) begin
                     // Half-period boundary: swap in the new divisor; a rest parks the output low.
                     st_reg.active    <= st_reg.pending;
                     st_reg.counter   <= load_count(st_reg.pending);
                     st_reg.phase     <= (st_reg.pending != '0) ? ~st_reg.phase : 1'b0;
                     st_reg.pend_flag <= 1'b0;
                  end else begin
                     st_reg.counter <= st_reg.active - 1'b1;
                     st_reg.phase   <= ~st_reg.phase;
                  end
               end
            end
         end

         assign tone_out[gi]   = st_reg.phase;
         assign pend_flags[gi] = st_reg.pend_flag;
      end
   endgenerate

`ifdef TONE_MIX_EN
   logic [MIX_W-1:0] mix_next;

   // Number of channels currently high.
   always_comb begin
      mix_next = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         mix_next = mix_next + MIX_W'(tone_out[i]);
      end
   end

   // Register the count so the mix lags tone_out by one clock.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mix_out <= '0;
      end else begin
         mix_out <= mix_next;
      end
   end
`endif

endmodule
